// File: rtl/pc_stack_counter.sv
`default_nettype none
// ============================================================================
//  Module   : pc_stack_counter
//  Purpose  : Registered program counter with jump, signed relative branch
//             and a LIFO return stack; sticky overflow/underflow flags.
//  Revision : 1.0  initial release
// ============================================================================
module pc_stack_counter #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           din,
  input  logic                       oe,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           pc,
  output logic [WIDTH-1:0]           pc_oe,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  localparam int LW    = $clog2(DEPTH + 1);
  // Stack index width; at least one bit so DEPTH=1 still has a legal index.
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << IW;

  localparam logic [2:0] c_op_hold   = 3'b000;
  localparam logic [2:0] c_op_inc    = 3'b001;
  localparam logic [2:0] c_op_jump   = 3'b010;
  localparam logic [2:0] c_op_branch = 3'b011;
  localparam logic [2:0] c_op_call   = 3'b100;
  localparam logic [2:0] c_op_ret    = 3'b101;

  logic [WIDTH-1:0] r_pc;
  logic [LW-1:0]    r_level;
  logic             r_ovf;
  logic             r_unf;
  logic [WIDTH-1:0] r_stack [SLOTS];

  logic [WIDTH-1:0] w_pc_next;
  logic [LW-1:0]    w_level_next;
  logic [WIDTH-1:0] w_pc_inc;
  logic [IW-1:0]    w_push_idx;
  logic [IW-1:0]    w_pop_idx;
  logic             w_push;
  logic             w_set_ovf;
  logic             w_set_unf;
  logic             w_full;
  logic             w_empty;

  assign w_full     = (r_level == LW'(DEPTH));
  assign w_empty    = (r_level == '0);
  assign w_pc_inc   = r_pc + WIDTH'(1);
  assign w_push_idx = IW'(r_level);
  assign w_pop_idx  = IW'(r_level) - IW'(1);

  // Decode the op into next PC, next level, push strobe and error events.
  // Branch offset needs no explicit sign extension: it has the PC's width,
  // so modulo-2^WIDTH addition of the raw bits is the signed add.
  always_comb begin
    w_pc_next    = r_pc;
    w_level_next = r_level;
    w_push       = 1'b0;
    w_set_ovf    = 1'b0;
    w_set_unf    = 1'b0;
    if (en) begin
      case (op)
        c_op_inc:    w_pc_next = w_pc_inc;
        c_op_jump:   w_pc_next = din;
        c_op_branch: w_pc_next = r_pc + din;
        c_op_call: begin
          if (w_full) begin
            w_set_ovf = 1'b1;
          end else begin
            w_push       = 1'b1;
            w_level_next = r_level + LW'(1);
            w_pc_next    = din;
          end
        end
        c_op_ret: begin
          if (w_empty) begin
            w_set_unf = 1'b1;
          end else begin
            w_level_next = r_level - LW'(1);
            w_pc_next    = r_stack[w_pop_idx];
          end
        end
        c_op_hold: w_pc_next = r_pc;
        default:   w_pc_next = r_pc;  // 110/111 behave as hold
      endcase
    end
  end

  // PC, level and sticky flags; a flag set on the same edge beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_VAL;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_level <= w_level_next;
      r_ovf   <= w_set_ovf | (r_ovf & ~err_clr);
      r_unf   <= w_set_unf | (r_unf & ~err_clr);
    end
  end

  // Return-stack storage; a push writes the return address at the slot
  // just above the current top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        r_stack[i] <= '0;
      end
    end else if (w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign pc    = r_pc;
  assign pc_oe = {WIDTH{oe}};
  assign level = r_level;
  assign full  = w_full;
  assign empty = w_empty;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_stack_counter
//  Purpose  : Directed self-checking bench; one instance at WIDTH=8/DEPTH=4,
//             one at WIDTH=12/DEPTH=1/RESET_VAL=0x100.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_stack_counter;

  localparam logic [2:0] HOLD = 3'b000, INC = 3'b001, JMP = 3'b010,
                         BRA = 3'b011, CALL = 3'b100, RET = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic oe = 1'b0;

  logic       en1 = 1'b0, clr1 = 1'b0;
  logic [2:0] op1 = '0;
  logic [7:0] din1 = '0;
  logic [7:0] pc1, pc_oe1;
  logic [2:0] level1;
  logic       full1, empty1, ovf1, unf1;

  logic        en2 = 1'b0, clr2 = 1'b0;
  logic [2:0]  op2 = '0;
  logic [11:0] din2 = '0;
  logic [11:0] pc2, pc_oe2;
  logic [0:0]  level2;
  logic        full2, empty2, ovf2, unf2;

  typedef struct {
    bit          sel;
    logic [11:0] pc;
    int          lvl;
    bit          ovf;
    bit          unf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  pc_stack_counter #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .op(op1), .din(din1), .oe(oe),
    .err_clr(clr1), .pc(pc1), .pc_oe(pc_oe1), .level(level1), .full(full1),
    .empty(empty1), .ovf(ovf1), .unf(unf1));

  pc_stack_counter #(.WIDTH(12), .DEPTH(1), .RESET_VAL(12'h100)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .op(op2), .din(din2), .oe(oe),
    .err_clr(clr2), .pc(pc2), .pc_oe(pc_oe2), .level(level2), .full(full2),
    .empty(empty2), .ovf(ovf2), .unf(unf2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one op, queue its expected result, then compare after the edge.
  task automatic step(input bit sel, input bit e, input logic [2:0] o,
                      input logic [11:0] d, input bit clr,
                      input logic [11:0] xpc, input int xlvl,
                      input bit xovf, input bit xunf);
    exp_t x;
    exp_t got;
    int   dep;
    @(negedge clk);
    if (!sel) begin
      en1 = e; op1 = o; din1 = d[7:0]; clr1 = clr;
    end else begin
      en2 = e; op2 = o; din2 = d; clr2 = clr;
    end
    x.sel = sel; x.pc = xpc; x.lvl = xlvl; x.ovf = xovf; x.unf = xunf;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    dep = got.sel ? 1 : 4;
    if (!got.sel) begin
      chk("pc1", 32'(pc1), 32'(got.pc));
      chk("level1", 32'(level1), 32'(got.lvl));
      chk("full1", 32'(full1), 32'(got.lvl == dep));
      chk("empty1", 32'(empty1), 32'(got.lvl == 0));
      chk("ovf1", 32'(ovf1), 32'(got.ovf));
      chk("unf1", 32'(unf1), 32'(got.unf));
    end else begin
      chk("pc2", 32'(pc2), 32'(got.pc));
      chk("level2", 32'(level2), 32'(got.lvl));
      chk("full2", 32'(full2), 32'(got.lvl == dep));
      chk("empty2", 32'(empty2), 32'(got.lvl == 0));
      chk("ovf2", 32'(ovf2), 32'(got.ovf));
      chk("unf2", 32'(unf2), 32'(got.unf));
    end
    en1 = 1'b0; clr1 = 1'b0; en2 = 1'b0; clr2 = 1'b0;
  endtask

  initial begin
    // Reset state while rst_n held low
    #23;
    chk("rst_pc1", 32'(pc1), 32'h00);
    chk("rst_empty1", 32'(empty1), 32'd1);
    chk("rst_full1", 32'(full1), 32'd0);
    chk("rst_ovf1", 32'(ovf1), 32'd0);
    chk("rst_unf1", 32'(unf1), 32'd0);
    chk("rst_pc2", 32'(pc2), 32'h100);
    chk("rst_level2", 32'(level2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Jump and increment with wrap
    step(0, 1, JMP, 12'hFE, 0, 12'hFE, 0, 0, 0);
    step(0, 1, INC, 12'h00, 0, 12'hFF, 0, 0, 0);
    step(0, 1, INC, 12'h00, 0, 12'h00, 0, 0, 0);
    step(0, 1, INC, 12'h00, 0, 12'h01, 0, 0, 0);

    // Signed relative branch, offset from current PC
    step(0, 1, JMP, 12'h10, 0, 12'h10, 0, 0, 0);
    step(0, 1, BRA, 12'hFC, 0, 12'h0C, 0, 0, 0);
    step(0, 1, BRA, 12'h7F, 0, 12'h8B, 0, 0, 0);
    step(0, 1, JMP, 12'hFF, 0, 12'hFF, 0, 0, 0);
    step(0, 1, BRA, 12'h02, 0, 12'h01, 0, 0, 0);

    // Fill the stack, overflow, drain, underflow
    step(0, 1, JMP,  12'h00, 0, 12'h00, 0, 0, 0);
    step(0, 1, CALL, 12'h20, 0, 12'h20, 1, 0, 0);
    step(0, 1, CALL, 12'h30, 0, 12'h30, 2, 0, 0);
    step(0, 1, CALL, 12'h40, 0, 12'h40, 3, 0, 0);
    step(0, 1, CALL, 12'h50, 0, 12'h50, 4, 0, 0);
    step(0, 1, CALL, 12'h99, 0, 12'h50, 4, 1, 0);
    step(0, 1, RET,  12'h00, 0, 12'h41, 3, 1, 0);
    step(0, 1, RET,  12'h00, 0, 12'h31, 2, 1, 0);
    step(0, 1, RET,  12'h00, 0, 12'h21, 1, 1, 0);
    step(0, 1, RET,  12'h00, 0, 12'h01, 0, 1, 0);
    step(0, 1, RET,  12'h00, 0, 12'h01, 0, 1, 1);
    step(0, 1, RET,  12'h00, 1, 12'h01, 0, 0, 1);
    step(0, 0, HOLD, 12'h00, 1, 12'h01, 0, 0, 0);

    // Back-to-back call then ret
    step(0, 1, CALL, 12'h60, 0, 12'h60, 1, 0, 0);
    step(0, 1, RET,  12'h00, 0, 12'h02, 0, 0, 0);

    // en low, unused op codes
    step(0, 0, JMP,    12'hAA, 0, 12'h02, 0, 0, 0);
    step(0, 1, 3'b110, 12'hAA, 0, 12'h02, 0, 0, 0);
    step(0, 1, 3'b111, 12'hAA, 0, 12'h02, 0, 0, 0);

    // Output enable is combinational and leaves pc alone
    #1 oe = 1'b1;
    #1;
    chk("pc_oe1_on", 32'(pc_oe1), 32'hFF);
    chk("pc_oe2_on", 32'(pc_oe2), 32'hFFF);
    chk("pc1_oe_on", 32'(pc1), 32'h02);
    oe = 1'b0;
    #1;
    chk("pc_oe1_off", 32'(pc_oe1), 32'h00);
    chk("pc1_oe_off", 32'(pc1), 32'h02);

    // Asynchronous reset between edges with two entries stacked
    step(0, 1, CALL, 12'h10, 0, 12'h10, 1, 0, 0);
    step(0, 1, CALL, 12'h33, 0, 12'h33, 2, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pc1", 32'(pc1), 32'h00);
    chk("async_level1", 32'(level1), 32'd0);
    chk("async_empty1", 32'(empty1), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, INC, 12'h00, 0, 12'h01, 0, 0, 0);
    step(0, 1, RET, 12'h00, 0, 12'h01, 0, 0, 1);

    // WIDTH=12, DEPTH=1 instance
    step(1, 1, CALL, 12'h200, 0, 12'h200, 1, 0, 0);
    step(1, 1, CALL, 12'h300, 0, 12'h200, 1, 1, 0);
    step(1, 1, RET,  12'h000, 0, 12'h101, 0, 1, 0);
    step(1, 1, RET,  12'h000, 0, 12'h101, 0, 1, 1);
    step(1, 0, HOLD, 12'h000, 1, 12'h101, 0, 0, 0);
    step(1, 1, JMP,  12'hFFF, 0, 12'hFFF, 0, 0, 0);
    step(1, 1, INC,  12'h000, 0, 12'h000, 0, 0, 0);
    step(1, 1, BRA,  12'hFFE, 0, 12'hFFE, 0, 0, 0);
    step(1, 1, CALL, 12'h0AB, 0, 12'h0AB, 1, 0, 0);
    step(1, 1, RET,  12'h000, 0, 12'hFFF, 0, 0, 0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
